// File: rtl/bus_mem_responder.sv
// bus_mem_responder: slave-side word-RAM responder for the arbitrated core bus.
// Accepts one request at a time. After a fixed wait it returns a single-cycle ack
// carrying the read data.
// Optional feature macro: ARVI_RESP_AMO_EN. It adds LR/SC reservations and AMO
// read-modify-write.
module bus_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_byte_en,
  input  logic        i_id,
`ifdef ARVI_RESP_AMO_EN
  input  logic        i_atomic,
  input  logic [6:0]  i_operation,
`endif
  output logic        o_ack,
  output logic [31:0] o_rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic going_ack;

  logic [ADDR_W-1:0] lat_idx;
  logic              lat_wr;
  logic [31:0]       lat_data;
  logic [3:0]        lat_be;

  logic [ADDR_W-1:0] cur_idx;
  logic              cur_wr;
  logic [31:0]       cur_data;
  logic [3:0]        cur_be;

  logic [31:0] mem [DEPTH];
  logic [31:0] old_word;
  logic        do_write;
  logic [31:0] wr_word;
  logic [3:0]  wr_mask;
  logic [31:0] resp;

`ifdef ARVI_RESP_AMO_EN
  logic              lat_id, lat_atomic;
  logic [6:0]        lat_op;
  logic              cur_id, cur_atomic, other_id;
  logic [6:0]        cur_op;
  logic [1:0]        resv_valid, resv_valid_next;
  logic [ADDR_W-1:0] resv_idx [2];
  logic [ADDR_W-1:0] resv_idx_next [2];
  logic              unused_bits;
  assign unused_bits = &{1'b0, i_addr[31:ADDR_W+2], i_addr[1:0], i_operation[1:0]};
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, i_addr[31:ADDR_W+2], i_addr[1:0], i_id};
`endif

  // Select the live bus fields in IDLE (LATENCY=1 acks on the sampling edge), latched copies otherwise
  always_comb begin
    cur_idx  = lat_idx;
    cur_wr   = lat_wr;
    cur_data = lat_data;
    cur_be   = lat_be;
`ifdef ARVI_RESP_AMO_EN
    cur_id     = lat_id;
    cur_atomic = lat_atomic;
    cur_op     = lat_op;
`endif
    if (state == IDLE) begin
      cur_idx  = i_addr[ADDR_W+1:2];
      cur_wr   = i_wr_en;
      cur_data = i_wr_data;
      cur_be   = i_byte_en;
`ifdef ARVI_RESP_AMO_EN
      cur_id     = i_id;
      cur_atomic = i_atomic;
      cur_op     = i_operation;
`endif
    end
  end

  assign old_word = mem[cur_idx];

  // Next-state logic: IDLE -> (WAIT) -> ACK -> IDLE, flagging the edge that enters ACK
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    going_ack  = 1'b0;
    case (state)
      IDLE: begin
        if (i_bus_en) begin
          if (LATENCY == 1) begin
            state_next = ACK;
            going_ack  = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ACK;
          going_ack  = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Work out the response word, the write to commit and the reservation updates for the current request
  always_comb begin
    do_write = 1'b0;
    wr_word  = cur_data;
    wr_mask  = cur_be;
    resp     = old_word;
`ifdef ARVI_RESP_AMO_EN
    other_id        = ~cur_id;
    resv_valid_next = resv_valid;
    resv_idx_next   = resv_idx;
    if (cur_atomic) begin
      case (cur_op[6:2])
        5'b00010: begin
          resv_valid_next[cur_id] = 1'b1;
          resv_idx_next[cur_id]   = cur_idx;
        end
        5'b00011: begin
          if (resv_valid[cur_id] && (resv_idx[cur_id] == cur_idx)) begin
            do_write = 1'b1;
            wr_mask  = 4'hF;
            resp     = 32'd0;
          end else begin
            resp = 32'd1;
          end
          resv_valid_next[cur_id] = 1'b0;
        end
        5'b00001: begin do_write = 1'b1; wr_mask = 4'hF; wr_word = cur_data; end
        5'b00000: begin do_write = 1'b1; wr_mask = 4'hF; wr_word = old_word + cur_data; end
        5'b00100: begin do_write = 1'b1; wr_mask = 4'hF; wr_word = old_word ^ cur_data; end
        5'b01100: begin do_write = 1'b1; wr_mask = 4'hF; wr_word = old_word & cur_data; end
        5'b01000: begin do_write = 1'b1; wr_mask = 4'hF; wr_word = old_word | cur_data; end
        5'b10000: begin
          do_write = 1'b1; wr_mask = 4'hF;
          wr_word  = ($signed(old_word) < $signed(cur_data)) ? old_word : cur_data;
        end
        5'b10100: begin
          do_write = 1'b1; wr_mask = 4'hF;
          wr_word  = ($signed(old_word) > $signed(cur_data)) ? old_word : cur_data;
        end
        5'b11000: begin
          do_write = 1'b1; wr_mask = 4'hF;
          wr_word  = (old_word < cur_data) ? old_word : cur_data;
        end
        5'b11100: begin
          do_write = 1'b1; wr_mask = 4'hF;
          wr_word  = (old_word > cur_data) ? old_word : cur_data;
        end
        default: ;
      endcase
    end else if (cur_wr) begin
      do_write = 1'b1;
      resp     = 32'd0;
    end
    if (do_write && resv_valid[other_id] && (resv_idx[other_id] == cur_idx))
      resv_valid_next[other_id] = 1'b0;
`else
    if (cur_wr) begin
      do_write = 1'b1;
      resp     = 32'd0;
    end
`endif
  end

  // State and wait-counter registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the request when it is first seen in IDLE
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_bus_en) begin
      lat_idx  <= i_addr[ADDR_W+1:2];
      lat_wr   <= i_wr_en;
      lat_data <= i_wr_data;
      lat_be   <= i_byte_en;
`ifdef ARVI_RESP_AMO_EN
      lat_id     <= i_id;
      lat_atomic <= i_atomic;
      lat_op     <= i_operation;
`endif
    end
  end

  // Registered ack pulse and response data, zero outside the ack cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_ack     <= 1'b0;
      o_rd_data <= 32'd0;
    end else begin
      o_ack     <= going_ack;
      o_rd_data <= going_ack ? resp : 32'd0;
    end
  end

`ifdef ARVI_RESP_AMO_EN
  // Reservation registers change only on the edge that completes a request
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      resv_valid  <= 2'b00;
      resv_idx[0] <= '0;
      resv_idx[1] <= '0;
    end else if (going_ack) begin
      resv_valid  <= resv_valid_next;
      resv_idx[0] <= resv_idx_next[0];
      resv_idx[1] <= resv_idx_next[1];
    end
  end
`endif

  // Commit the write with lane masking, suppressed while reset is asserted
  always_ff @(posedge i_clk) begin
    if (i_rst && going_ack && do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[cur_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed, table-driven bench for bus_mem_responder.
// It uses a LATENCY=1 instance and a LATENCY=4 instance.
// The AMO sequences compile only when ARVI_RESP_AMO_EN is defined.
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_en1 = 1'b0, bus_en4 = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  byte_en = 4'd0;
  logic        id = 1'b0;
`ifdef ARVI_RESP_AMO_EN
  logic        atomic = 1'b0;
  logic [6:0]  operation = 7'd0;
`endif
  logic        ack1, ack4;
  logic [31:0] rd1, rd4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        id;
    logic        atomic;
    logic [6:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(bus_en1), .i_wr_en(wr_en),
    .i_wr_data(wr_data), .i_addr(addr), .i_byte_en(byte_en), .i_id(id),
`ifdef ARVI_RESP_AMO_EN
    .i_atomic(atomic), .i_operation(operation),
`endif
    .o_ack(ack1), .o_rd_data(rd1)
  );

  bus_mem_responder #(.ADDR_W(10), .LATENCY(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(bus_en4), .i_wr_en(wr_en),
    .i_wr_data(wr_data), .i_addr(addr), .i_byte_en(byte_en), .i_id(id),
`ifdef ARVI_RESP_AMO_EN
    .i_atomic(atomic), .i_operation(operation),
`endif
    .o_ack(ack4), .o_rd_data(rd4)
  );

  // Compare one value and report a failure line when it differs
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic hid, input logic at,
                              input logic [6:0] op, input logic [31:0] exp);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.be = be; v.id = hid;
    v.atomic = at; v.op = op; v.exp = exp;
    return v;
  endfunction

  // Issue one request to the selected instance and check ack timing and data
  task automatic apply_stimulus(input bit use4, input vec_t v, input string name);
    int lat;
    logic        a;
    logic [31:0] r;
    lat = use4 ? 4 : 1;
    @(negedge clk);
    wr_en = v.wr; addr = v.addr; wr_data = v.data; byte_en = v.be; id = v.id;
`ifdef ARVI_RESP_AMO_EN
    atomic = v.atomic; operation = v.op;
`endif
    if (use4) bus_en4 = 1'b1; else bus_en1 = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      a = use4 ? ack4 : ack1;
      r = use4 ? rd4 : rd1;
      if (c < lat) begin
        check_output({name, " early ack"}, {31'd0, a}, 32'd0);
        check_output({name, " early data"}, r, 32'd0);
      end else begin
        check_output({name, " ack"}, {31'd0, a}, 32'd1);
        check_output({name, " data"}, r, v.exp);
      end
    end
    bus_en1 = 1'b0; bus_en4 = 1'b0;
    @(posedge clk); #1;
    a = use4 ? ack4 : ack1;
    r = use4 ? rd4 : rd1;
    check_output({name, " ack drop"}, {31'd0, a}, 32'd0);
    check_output({name, " data drop"}, r, 32'd0);
  endtask

  initial begin
    bit saw_ack;
    $display("[TB] start");

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset ack1", {31'd0, ack1}, 32'd0);
    check_output("reset rd1", rd1, 32'd0);
    check_output("reset ack4", {31'd0, ack4}, 32'd0);
    check_output("reset rd4", rd4, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // LATENCY=1 plain read/write table
    vecs.push_back(mk(1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 7'd0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h10,   32'h0,        4'hF, 1'b0, 1'b0, 7'd0, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 32'h14,   32'h11223344, 4'hF, 1'b0, 1'b0, 7'd0, 32'h0));
    vecs.push_back(mk(1'b1, 32'h14,   32'hAAAAAAAA, 4'h5, 1'b1, 1'b0, 7'd0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h14,   32'h0,        4'hF, 1'b0, 1'b0, 7'd0, 32'h11AA33AA));
    vecs.push_back(mk(1'b1, 32'h14,   32'hFFFFFFFF, 4'h8, 1'b0, 1'b0, 7'd0, 32'h0));
    vecs.push_back(mk(1'b0, 32'h14,   32'h0,        4'h0, 1'b0, 1'b0, 7'd0, 32'hFFAA33AA));
    vecs.push_back(mk(1'b0, 32'h1012, 32'h0,        4'h0, 1'b1, 1'b0, 7'd0, 32'hDEADBEEF));
    vecs.push_back(mk(1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 7'd0, 32'h0));
    vecs.push_back(mk(1'b0, 32'hFFC,  32'h0,        4'hF, 1'b0, 1'b0, 7'd0, 32'hCAFEF00D));
    foreach (vecs[i]) apply_stimulus(1'b0, vecs[i], $sformatf("L1 vec%0d", i));

    // LATENCY=4 timing and data
    apply_stimulus(1'b1, mk(1'b1, 32'h10, 32'h5A5A1234, 4'hF, 1'b0, 1'b0, 7'd0, 32'h0), "L4 write");
    apply_stimulus(1'b1, mk(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 7'd0, 32'h5A5A1234), "L4 read");
    apply_stimulus(1'b1, mk(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, 1'b0, 7'd0, 32'h0), "L4 pre");

    // Reset asserted while the LATENCY=4 instance waits on a write
    @(negedge clk);
    wr_en = 1'b1; addr = 32'h20; wr_data = 32'h55; byte_en = 4'hF; bus_en4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus_en4 = 1'b0;
    saw_ack = 1'b0;
    @(posedge clk); #1;
    if (ack4) saw_ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack4) saw_ack = 1'b1;
    end
    check_output("abort no ack", {31'd0, saw_ack}, 32'd0);
    apply_stimulus(1'b1, mk(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, 7'd0, 32'h12345678), "L4 after abort");

`ifdef ARVI_RESP_AMO_EN
    // Reservation lost to the other hart's AMO
    apply_stimulus(1'b0, mk(1'b1, 32'h40, 32'd7, 4'hF, 1'b0, 1'b0, 7'd0, 32'd0), "amo init");
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'd0, 4'hF, 1'b0, 1'b1, {5'b00010, 2'b00}, 32'd7), "lr0");
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'd3, 4'hF, 1'b1, 1'b1, {5'b00000, 2'b00}, 32'd7), "amoadd1");
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'h99, 4'hF, 1'b0, 1'b1, {5'b00011, 2'b00}, 32'd1), "sc0 fail");
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'd0, 4'hF, 1'b0, 1'b0, 7'd0, 32'd10), "mem 10");
    // Successful SC, then a repeated SC without a reservation
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'd0, 4'hF, 1'b0, 1'b1, {5'b00010, 2'b01}, 32'd10), "lr0 b");
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'h99, 4'h0, 1'b0, 1'b1, {5'b00011, 2'b10}, 32'd0), "sc0 ok");
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'd0, 4'hF, 1'b0, 1'b0, 7'd0, 32'h99), "mem 99");
    apply_stimulus(1'b0, mk(1'b0, 32'h40, 32'h77, 4'hF, 1'b0, 1'b1, {5'b00011, 2'b00}, 32'd1), "sc0 again");
    // Signed versus unsigned minimum
    apply_stimulus(1'b0, mk(1'b1, 32'h44, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, 7'd0, 32'd0), "min init");
    apply_stimulus(1'b0, mk(1'b0, 32'h44, 32'd5, 4'hF, 1'b0, 1'b1, {5'b10000, 2'b00}, 32'hFFFFFFFF), "amomin");
    apply_stimulus(1'b0, mk(1'b0, 32'h44, 32'd0, 4'hF, 1'b0, 1'b0, 7'd0, 32'hFFFFFFFF), "min mem");
    apply_stimulus(1'b0, mk(1'b0, 32'h44, 32'd5, 4'hF, 1'b0, 1'b1, {5'b11000, 2'b00}, 32'hFFFFFFFF), "amominu");
    apply_stimulus(1'b0, mk(1'b0, 32'h44, 32'd0, 4'hF, 1'b0, 1'b0, 7'd0, 32'd5), "minu mem");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
